// File: rtl/elevador_parametrizado.sv
// rtl/elevador_parametrizado.sv - parametrised SCAN elevator controller with door phase and emergency descent
module elevador_parametrizado #(
   parameter int NUM_FLOORS  = 5,
   parameter int MAX_PEOPLE  = 3,
   parameter int MOVE_CYCLES = 100,
   parameter int DOOR_CYCLES = 20,
   localparam int FW = $clog2(NUM_FLOORS + 1),
   localparam int PW = $clog2(MAX_PEOPLE + 1)
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic                  add_person,
   input  logic                  rem_person,
   input  logic                  emergency,
   output logic [FW-1:0]         floor,
   output logic [PW-1:0]         people,
   output logic [NUM_FLOORS-1:0] calls,
   output logic                  full,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic                  emergency_mode
);

   localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int DCW = $clog2(DOOR_CYCLES + 1);

   localparam logic [FW-1:0]  FLOOR_BOTTOM = FW'(1);
   localparam logic [FW-1:0]  FLOOR_TOP    = FW'(NUM_FLOORS);
   localparam logic [PW-1:0]  PEOPLE_MAX   = PW'(MAX_PEOPLE);
   localparam logic [MCW-1:0] MOVE_LAST    = MCW'(MOVE_CYCLES - 1);
   localparam logic [DCW-1:0] DOOR_LAST    = DCW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MOVING,
      S_DOOR,
      S_EMERG
   } state_t;

   state_t state, state_n;

   logic [FW-1:0]         floor_n;
   logic [PW-1:0]         people_n;
   logic [NUM_FLOORS-1:0] calls_n;
   logic                  dir_up_n;
   logic [MCW-1:0]        move_cnt, move_cnt_n;
   logic [DCW-1:0]        door_cnt, door_cnt_n;

   logic add_prev, rem_prev, emerg_prev;
   logic add_edge, rem_edge, emerg_edge;

   logic [NUM_FLOORS-1:0] cur_mask;
   logic [NUM_FLOORS-1:0] arr_mask;
   logic [NUM_FLOORS-1:0] calls_lat;
   logic [FW-1:0]         next_floor;
   logic                  has_above, has_below;
   logic                  is_full;

   assign add_edge   = add_person & ~add_prev;
   assign rem_edge   = rem_person & ~rem_prev;
   assign emerg_edge = emergency  & ~emerg_prev;

   assign is_full        = (people == PEOPLE_MAX);
   assign full           = is_full;
   assign moving         = (state == S_MOVING) || ((state == S_EMERG) && (floor != FLOOR_BOTTOM));
   assign door_open      = (state == S_DOOR);
   assign emergency_mode = (state == S_EMERG);

   // Edge-detect history for the three level inputs
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         add_prev   <= 1'b0;
         rem_prev   <= 1'b0;
         emerg_prev <= 1'b0;
      end else begin
         add_prev   <= add_person;
         rem_prev   <= rem_person;
         emerg_prev <= emergency;
      end
   end

   // Floor-relative views of the call vector: current floor, arrival floor, calls ahead/behind
   always_comb begin
      cur_mask  = '0;
      arr_mask  = '0;
      has_above = 1'b0;
      has_below = 1'b0;
      if (dir_up)
         next_floor = (floor == FLOOR_TOP) ? floor : floor + FW'(1);
      else
         next_floor = (floor == FLOOR_BOTTOM) ? floor : floor - FW'(1);
      for (int i = 0; i < NUM_FLOORS; i++) begin
         cur_mask[i] = (floor == FW'(i + 1));
         arr_mask[i] = (next_floor == FW'(i + 1));
         if (calls[i] && (FW'(i + 1) > floor)) has_above = 1'b1;
         if (calls[i] && (FW'(i + 1) < floor)) has_below = 1'b1;
      end
   end

   // Next-state and datapath update; emergency entry overrides the per-state result last
   always_comb begin
      state_n    = state;
      floor_n    = floor;
      people_n   = people;
      calls_n    = calls;
      dir_up_n   = dir_up;
      move_cnt_n = move_cnt;
      door_cnt_n = door_cnt;
      calls_lat  = calls | call_req;

      // Boarding only while the cabin is stationary; simultaneous add and remove cancel
      if ((state == S_IDLE) || (state == S_DOOR)) begin
         if (add_edge && !rem_edge && (people != PEOPLE_MAX))
            people_n = people + PW'(1);
         else if (rem_edge && !add_edge && (people != '0))
            people_n = people - PW'(1);
      end

      case (state)
         S_IDLE: begin
            // A call for the floor we are already at opens the door instead of being queued
            calls_n = calls | (call_req & ~cur_mask);
            if (|(call_req & cur_mask)) begin
               state_n    = S_DOOR;
               door_cnt_n = '0;
            end else if (!is_full && (has_above || has_below)) begin
               state_n    = S_MOVING;
               move_cnt_n = '0;
               dir_up_n   = dir_up ? has_above : !has_below;
            end
         end

         S_MOVING: begin
            calls_n = calls_lat;
            if (move_cnt == MOVE_LAST) begin
               move_cnt_n = '0;
               floor_n    = next_floor;
               if (|(calls_lat & arr_mask)) begin
                  calls_n    = calls_lat & ~arr_mask;
                  state_n    = S_DOOR;
                  door_cnt_n = '0;
               end else if ((next_floor == FLOOR_TOP) || (next_floor == FLOOR_BOTTOM)) begin
                  // Nothing left ahead at an end floor: stop rather than run off the shaft
                  state_n = S_IDLE;
               end
            end else begin
               move_cnt_n = move_cnt + MCW'(1);
            end
         end

         S_DOOR: begin
            calls_n = calls | (call_req & ~cur_mask);
            if (|(call_req & cur_mask))
               door_cnt_n = '0;
            else if (door_cnt == DOOR_LAST) begin
               state_n    = S_IDLE;
               door_cnt_n = '0;
            end else
               door_cnt_n = door_cnt + DCW'(1);
         end

         S_EMERG: begin
            calls_n  = '0;
            dir_up_n = 1'b0;
            if (floor == FLOOR_BOTTOM) begin
               state_n    = S_DOOR;
               move_cnt_n = '0;
               door_cnt_n = '0;
            end else if (move_cnt == MOVE_LAST) begin
               move_cnt_n = '0;
               floor_n    = floor - FW'(1);
            end else begin
               move_cnt_n = move_cnt + MCW'(1);
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Emergency wins over arrival; any floor step committed above is kept
      if (emerg_edge && (state != S_EMERG)) begin
         state_n    = S_EMERG;
         calls_n    = '0;
         move_cnt_n = '0;
         door_cnt_n = '0;
         dir_up_n   = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // Datapath registers: position, occupancy, pending calls, direction and timers
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         floor    <= FLOOR_BOTTOM;
         people   <= '0;
         calls    <= '0;
         dir_up   <= 1'b1;
         move_cnt <= '0;
         door_cnt <= '0;
      end else begin
         floor    <= floor_n;
         people   <= people_n;
         calls    <= calls_n;
         dir_up   <= dir_up_n;
         move_cnt <= move_cnt_n;
         door_cnt <= door_cnt_n;
      end
   end

endmodule

// File: tb/tb_elevador_parametrizado.sv
// tb/tb_elevador_parametrizado.sv - table-driven scoreboard bench for elevador_parametrizado
module tb_elevador_parametrizado;

   logic       CLOCK_50;
   logic       RESET;
   logic [4:0] call_req;
   logic       add_person;
   logic       rem_person;
   logic       emergency;
   logic [2:0] floor;
   logic [1:0] people;
   logic [4:0] calls;
   logic       full;
   logic       moving;
   logic       dir_up;
   logic       door_open;
   logic       emergency_mode;

   int checks = 0;
   int errors = 0;

   elevador_parametrizado #(
      .NUM_FLOORS(5),
      .MAX_PEOPLE(3),
      .MOVE_CYCLES(100),
      .DOOR_CYCLES(20)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET(RESET),
      .call_req(call_req),
      .add_person(add_person),
      .rem_person(rem_person),
      .emergency(emergency),
      .floor(floor),
      .people(people),
      .calls(calls),
      .full(full),
      .moving(moving),
      .dir_up(dir_up),
      .door_open(door_open),
      .emergency_mode(emergency_mode)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // Inputs are pulsed for one clock, then the bench waits cyc clocks in total and samples
   typedef struct {
      logic [4:0] req;
      bit         add;
      bit         rem;
      bit         emg;
      int         cyc;
      int         exp_floor;
      int         exp_people;
      logic [4:0] exp_calls;
      bit         exp_moving;
      bit         exp_dir_up;
      bit         exp_door;
      bit         exp_emerg;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(input logic [4:0] req, input bit a, input bit r, input bit e,
                               input int cyc, input int fl, input int pp, input logic [4:0] cl,
                               input bit mv, input bit du, input bit dr, input bit em);
      vec_t v;
      v.req = req; v.add = a; v.rem = r; v.emg = e; v.cyc = cyc;
      v.exp_floor = fl; v.exp_people = pp; v.exp_calls = cl;
      v.exp_moving = mv; v.exp_dir_up = du; v.exp_door = dr; v.exp_emerg = em;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      vec_t cur;
      vec_t ev;

      //                req      a  r  e  cyc  fl pp calls    mv du dr em
      // occupancy
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 1, 0, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 1, 0, 0,   2, 1, 1, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 1, 0, 0,   2, 1, 2, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 1, 0, 0,   2, 1, 3, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 1, 0, 0,   2, 1, 3, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 1, 0,   2, 1, 2, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 1, 1, 0,   2, 1, 2, 5'b00000, 0, 1, 0, 0));
      // single trip 1 -> 3 with door phase
      vecs.push_back(mk(5'b00100, 0, 0, 0,   1, 1, 2, 5'b00100, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 1, 2, 5'b00100, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  99, 1, 2, 5'b00100, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 2, 2, 5'b00100, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 100, 3, 2, 5'b00000, 0, 1, 1, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  19, 3, 2, 5'b00000, 0, 1, 1, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 3, 2, 5'b00000, 0, 1, 0, 0));
      // full cabin holds a call until someone leaves
      vecs.push_back(mk(5'b00000, 1, 0, 0,   2, 3, 3, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00001, 0, 0, 0,   1, 3, 3, 5'b00001, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 300, 3, 3, 5'b00001, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 1, 0,   1, 3, 2, 5'b00001, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 3, 2, 5'b00001, 1, 0, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 199, 2, 2, 5'b00001, 1, 0, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 1, 2, 5'b00000, 0, 0, 1, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  20, 1, 2, 5'b00000, 0, 0, 0, 0));
      // SCAN: go to 3 heading up, then calls at 2 and 5 together
      vecs.push_back(mk(5'b00100, 0, 0, 0, 202, 3, 2, 5'b00000, 0, 1, 1, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  20, 3, 2, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(5'b10010, 0, 0, 0,   1, 3, 2, 5'b10010, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 3, 2, 5'b10010, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 200, 5, 2, 5'b00010, 0, 1, 1, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  20, 5, 2, 5'b00010, 0, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 5, 2, 5'b00010, 1, 0, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 300, 2, 2, 5'b00000, 0, 0, 1, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  20, 2, 2, 5'b00000, 0, 0, 0, 0));
      // emergency mid-move above floor 4 with every call pending
      vecs.push_back(mk(5'b10000, 0, 0, 0,   2, 2, 2, 5'b10000, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 200, 4, 2, 5'b10000, 1, 1, 0, 0));
      vecs.push_back(mk(5'b11111, 0, 0, 0,   1, 4, 2, 5'b11111, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  49, 4, 2, 5'b11111, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 1,   1, 4, 2, 5'b00000, 1, 0, 0, 1));
      vecs.push_back(mk(5'b00100, 1, 0, 1,   1, 4, 2, 5'b00000, 1, 0, 0, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 298, 2, 2, 5'b00000, 1, 0, 0, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 1, 2, 5'b00000, 0, 0, 0, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 0,   1, 1, 2, 5'b00000, 0, 0, 1, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0,  20, 1, 2, 5'b00000, 0, 0, 0, 0));
      // set up a move through floor 3 for the asynchronous reset
      vecs.push_back(mk(5'b10000, 0, 0, 0,   2, 1, 2, 5'b10000, 1, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 250, 3, 2, 5'b10000, 1, 1, 0, 0));

      RESET      = 1'b1;
      call_req   = '0;
      add_person = 1'b0;
      rem_person = 1'b0;
      emergency  = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      RESET = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         cur        = vecs[k];
         call_req   = cur.req;
         add_person = cur.add;
         rem_person = cur.rem;
         emergency  = cur.emg;
         sb.push_back(cur);
         @(posedge CLOCK_50);
         #1;
         call_req   = '0;
         add_person = 1'b0;
         rem_person = 1'b0;
         emergency  = 1'b0;
         repeat (cur.cyc - 1) @(posedge CLOCK_50);
         @(negedge CLOCK_50);
         ev = sb.pop_front();
         chk($sformatf("v%0d.floor", k),   32'(floor),          32'(ev.exp_floor));
         chk($sformatf("v%0d.people", k),  32'(people),         32'(ev.exp_people));
         chk($sformatf("v%0d.calls", k),   32'(calls),          32'(ev.exp_calls));
         chk($sformatf("v%0d.full", k),    32'(full),           32'(ev.exp_people == 3));
         chk($sformatf("v%0d.moving", k),  32'(moving),         32'(ev.exp_moving));
         chk($sformatf("v%0d.dir_up", k),  32'(dir_up),         32'(ev.exp_dir_up));
         chk($sformatf("v%0d.door", k),    32'(door_open),      32'(ev.exp_door));
         chk($sformatf("v%0d.emerg", k),   32'(emergency_mode), 32'(ev.exp_emerg));
      end

      // Asynchronous reset between clock edges while moving at floor 3
      RESET      = 1'b1;
      add_person = 1'b1;
      #1;
      chk("areset.floor",  32'(floor),          32'd1);
      chk("areset.people", 32'(people),         32'd0);
      chk("areset.calls",  32'(calls),          32'd0);
      chk("areset.moving", 32'(moving),         32'd0);
      chk("areset.dir_up", 32'(dir_up),         32'd1);
      chk("areset.door",   32'(door_open),      32'd0);
      chk("areset.emerg",  32'(emergency_mode), 32'd0);
      chk("areset.full",   32'(full),           32'd0);
      RESET = 1'b0;

      // add_person held high across reset release counts exactly once
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("held_add.first", 32'(people), 32'd1);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("held_add.second", 32'(people), 32'd1);
      add_person = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/elevador_parametrizado.md
Name: elevador_parametrizado

Overview:
Parametrised elevator controller, successor to the fixed 5-floor/3-person board elevator. Supports N floors, configurable capacity, move and door-dwell timing, and SCAN (direction-preserving) call scheduling. Adds an explicit door-open phase and an emergency descent that aborts a move in progress. Display and 7-segment decoding stay in the board top level; this block exposes raw state only.

Parameters:
NUM_FLOORS, 5, number of floors (>=2); floors numbered 1..NUM_FLOORS
MAX_PEOPLE, 3, capacity; full when people == MAX_PEOPLE
MOVE_CYCLES, 100, clock cycles to travel one floor (>=2)
DOOR_CYCLES, 20, clock cycles the door stays open (>=1)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
call_req  in  NUM_FLOORS  level call requests; bit i = floor i+1
add_person  in  1  level; each rising edge adds one person
rem_person  in  1  level; each rising edge removes one person
emergency  in  1  level; rising edge starts emergency descent
floor  out  FW=$clog2(NUM_FLOORS+1)  current floor, 1-based
people  out  PW=$clog2(MAX_PEOPLE+1)  occupant count
calls  out  NUM_FLOORS  latched pending calls
full  out  1  people == MAX_PEOPLE
moving  out  1  high in MOVING and while descending in EMERG
dir_up  out  1  current/last travel direction, 1 = up
door_open  out  1  high in DOOR state
emergency_mode  out  1  high in EMERG state

Behaviour:
- Reset (async): state IDLE, floor=1, people=0, calls=0, dir_up=1, move/door counters 0, edge-detect registers 0; all flags 0. An input held high across reset release yields one rising edge on the first clock after release.
- Edge detect: one register per level input; edge = in & ~prev.
- People: accepted only in IDLE/DOOR. Add edge with people<MAX_PEOPLE: +1. Rem edge with people>0: -1. Both in the same cycle: no change. Saturate at both ends; edges in MOVING/EMERG are discarded.
- Call latch (not in EMERG): calls |= call_req every cycle, except that in IDLE/DOOR the bit for the current floor is not latched. In IDLE it causes IDLE->DOOR instead; in DOOR it restarts the door counter. During MOVING, the current-floor bit is latched normally.
- States: IDLE, MOVING, DOOR, EMERG.
- IDLE: if calls!=0 and !full, depart next cycle. Direction selection:
  - keep dir_up if a call lies in that direction;
  - else reverse if a call lies in the opposite direction.
  - If full, remain IDLE with calls held.
- MOVING: counter counts 0..MOVE_CYCLES-1, then floor +/-1 and counter clears. Arrival f->f±1 therefore occurs exactly MOVE_CYCLES cycles after entering MOVING.
  - On arrival, if calls[new floor] is set: clear that bit and go to DOOR.
  - Otherwise keep moving in the same direction. A call always exists ahead, because calls are cleared only by service or emergency.
  - floor never leaves 1..NUM_FLOORS. full is ignored while moving.
- DOOR: door_open=1 for DOOR_CYCLES cycles, then IDLE. IDLE re-evaluates calls on the following cycle.
- EMERG entry: emergency edge in any state except EMERG.
  - Next cycle: calls=0, emergency_mode=1, move counter=0, dir_up=0.
  - A partial move is abandoned; floor keeps its last committed value.
  - Edges on emergency during EMERG are ignored; calls are not latched; full does not block descent.
- EMERG operation: if floor>1, descend one floor per MOVE_CYCLES with moving=1. When floor==1, on the next cycle emergency_mode=0 and the state goes to DOOR.
- Simultaneous emergency edge and arrival at a called floor: emergency wins. The floor update of that cycle is committed, but the call is cleared and DOOR is not entered.
- Widths: all counters sized by $clog2. No wrap-around is permitted on floor, people or counters.

Test Plan:
Use defaults (5 floors, MAX_PEOPLE=3, MOVE_CYCLES=100, DOOR_CYCLES=20).
1. Reset, then 4 add edges and 1 rem edge -> people reaches 3 and saturates (full=1), then 2 after the rem. Simultaneous add+rem -> people stays 2.
2. At floor 1, call_req=00100 -> depart 1 cycle later. floor=2 after 100 cycles, floor=3 after 200 cycles. At arrival door_open=1 for 20 cycles, calls=00000, then IDLE.
3. At floor 3 with people=3, call_req=00001 -> calls=00001 latched, floor stays 3 for 300 cycles. One rem edge -> departs, reaches floor 1 after 200 more cycles.
4. At floor 3, dir_up=1, calls 00010 and 10000 set together -> SCAN serves floor 5 first (door at 5), then floor 2. Final calls=00000, dir_up=0.
5. At floor 4 moving up with calls=11111, assert emergency mid-move -> calls=00000 and emergency_mode=1 next cycle, floor stays 4. floor reaches 1 after 300 cycles, then emergency_mode=0 and door_open=1. call_req pulses during EMERG are not latched.
6. Assert RESET for 1 ns mid-move at floor 3 -> all outputs return immediately to reset values (floor=1, calls=0, people=0), independent of CLOCK_50.
